// File: rtl/ghpc_latency_scheduler.sv
// Sequencer for a serialised GHPC masked S-box: paces NUM_BLOCKS evaluations of LATENCY cycles each,
// emits the Synch capture pulse and a glitch-free gated clock that ticks only at Synch edges.
module ghpc_latency_scheduler #(
    parameter int LATENCY    = 11,
    parameter int NUM_BLOCKS = 16,
    parameter int MODE       = 1,
    localparam int BW        = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_out_ready,
    output logic          o_in_ready,
    output logic          o_busy,
    output logic          o_fresh_en,
    output logic [BW-1:0] o_blk_idx,
    output logic          o_synch,
    output logic          o_gated_clk,
    output logic          o_out_valid
);

    localparam bit            FREE_RUN = (MODE == 0);
    localparam logic [7:0]    LAST_CNT = 8'(LATENCY - 1);
    localparam logic [BW-1:0] LAST_BLK = BW'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [7:0]    r_cnt;
    logic [BW-1:0] r_blk;
    logic          r_in_ready;
    logic          r_busy;
    logic          r_fresh_en;
    logic          r_out_valid;
    logic          r_gate_en;

    state_t        w_nxt_state;
    logic [7:0]    w_nxt_cnt;
    logic [BW-1:0] w_nxt_blk;
    logic          w_last_cnt;
    logic          w_last_blk;
    logic          w_synch;

    assign w_last_cnt = (r_cnt == LAST_CNT);
    assign w_last_blk = (r_blk == LAST_BLK);

    // Synch is qualified by the same-cycle abort, so it cannot come from a flop.
    always_comb begin
        w_synch = 1'b0;
        if (i_rst) begin
            w_synch = 1'b0;
        end else if (FREE_RUN) begin
            w_synch = w_last_cnt;
        end else begin
            w_synch = (r_state == ST_RUN) && w_last_cnt && !i_abort;
        end
    end

    // Next-state, cycle counter and block index.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_blk   = r_blk;
        if (FREE_RUN) begin
            w_nxt_state = ST_RUN;
            w_nxt_cnt   = w_last_cnt ? 8'd0 : r_cnt + 8'd1;
            if (w_last_cnt) begin
                w_nxt_blk = w_last_blk ? {BW{1'b0}} : r_blk + BW'(1);
            end else begin
                w_nxt_blk = r_blk;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_nxt_state = ST_RUN;
                        w_nxt_cnt   = 8'd0;
                        w_nxt_blk   = {BW{1'b0}};
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_cnt   = 8'd0;
                        w_nxt_blk   = {BW{1'b0}};
                    end else if (w_last_cnt) begin
                        w_nxt_cnt = 8'd0;
                        if (w_last_blk) begin
                            w_nxt_state = ST_DONE;
                        end else begin
                            w_nxt_blk = r_blk + BW'(1);
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (i_abort || i_out_ready) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_cnt   = 8'd0;
                        w_nxt_blk   = {BW{1'b0}};
                    end else begin
                        w_nxt_state = ST_DONE;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = 8'd0;
                    w_nxt_blk   = {BW{1'b0}};
                end
            endcase
        end
    end

    // State registers; status outputs are registered decodes of the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_blk       <= {BW{1'b0}};
            r_in_ready  <= !FREE_RUN;
            r_busy      <= 1'b0;
            r_fresh_en  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_blk       <= w_nxt_blk;
            r_in_ready  <= !FREE_RUN && (w_nxt_state == ST_IDLE);
            r_busy      <= FREE_RUN || (w_nxt_state != ST_IDLE);
            r_fresh_en  <= FREE_RUN || (w_nxt_state == ST_RUN);
            r_out_valid <= !FREE_RUN && (w_nxt_state == ST_DONE);
        end
    end

    // Clock-gate enable latch: transparent in the low phase so the AND below cannot glitch.
    always_latch begin
        if (!i_clk) begin
            r_gate_en <= w_synch;
        end
    end

    assign o_gated_clk = i_clk & r_gate_en;
    assign o_synch     = w_synch;
    assign o_in_ready  = r_in_ready;
    assign o_busy      = r_busy;
    assign o_fresh_en  = r_fresh_en;
    assign o_blk_idx   = r_blk;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_ghpc_latency_scheduler.sv
// Scoreboard bench: stimulus pushes expected Synch/out_valid events, negedge monitors pop and compare.
module tb_ghpc_latency_scheduler;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: LATENCY=11, NUM_BLOCKS=4, handshake mode
    logic       a_rst = 1'b1, a_start = 1'b0, a_abort = 1'b0, a_out_ready = 1'b0;
    logic       a_in_ready, a_busy, a_fresh, a_synch, a_gclk, a_valid;
    logic [1:0] a_blk;
    // DUT B: LATENCY=11, NUM_BLOCKS=4, free-run
    logic       b_rst = 1'b1, b_start = 1'b0, b_abort = 1'b0, b_out_ready = 1'b0;
    logic       b_in_ready, b_busy, b_fresh, b_synch, b_gclk, b_valid;
    logic [1:0] b_blk;
    // DUT C: LATENCY=2, NUM_BLOCKS=1, handshake mode
    logic       c_rst = 1'b1, c_start = 1'b0, c_abort = 1'b0, c_out_ready = 1'b0;
    logic       c_in_ready, c_busy, c_fresh, c_synch, c_gclk, c_valid;
    logic [0:0] c_blk;

    ghpc_latency_scheduler #(.LATENCY(11), .NUM_BLOCKS(4), .MODE(1)) u_a (
        .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_abort(a_abort), .i_out_ready(a_out_ready),
        .o_in_ready(a_in_ready), .o_busy(a_busy), .o_fresh_en(a_fresh), .o_blk_idx(a_blk),
        .o_synch(a_synch), .o_gated_clk(a_gclk), .o_out_valid(a_valid));

    ghpc_latency_scheduler #(.LATENCY(11), .NUM_BLOCKS(4), .MODE(0)) u_b (
        .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_abort(b_abort), .i_out_ready(b_out_ready),
        .o_in_ready(b_in_ready), .o_busy(b_busy), .o_fresh_en(b_fresh), .o_blk_idx(b_blk),
        .o_synch(b_synch), .o_gated_clk(b_gclk), .o_out_valid(b_valid));

    ghpc_latency_scheduler #(.LATENCY(2), .NUM_BLOCKS(1), .MODE(1)) u_c (
        .i_clk(clk), .i_rst(c_rst), .i_start(c_start), .i_abort(c_abort), .i_out_ready(c_out_ready),
        .o_in_ready(c_in_ready), .o_busy(c_busy), .o_fresh_en(c_fresh), .o_blk_idx(c_blk),
        .o_synch(c_synch), .o_gated_clk(c_gclk), .o_out_valid(c_valid));

    int a_syn_cyc[$], a_syn_blk[$], a_val_cyc[$];
    int b_syn_cyc[$], b_syn_blk[$];
    int c_syn_cyc[$], c_val_cyc[$];
    int a_exp_gclk = 0, a_gclk_n = 0, b_gclk_n = 0, c_exp_gclk = 0, c_gclk_n = 0;
    logic a_valid_q = 1'b0, c_valid_q = 1'b0, b_win = 1'b0;
    int b_end = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_push_synch(input int cy, input int blk);
        a_syn_cyc.push_back(cy);
        a_syn_blk.push_back(blk);
        a_exp_gclk++;
    endtask

    task automatic a_push_run(input int e0);
        for (int k = 0; k < 4; k++) a_push_synch(e0 + 11 * k + 10, k);
        a_val_cyc.push_back(e0 + 44);
    endtask

    task automatic do_a_start(output int e0);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        e0 = cyc;
    endtask

    task automatic do_c_start(output int e0);
        c_start = 1'b1;
        @(posedge clk);
        #1;
        c_start = 1'b0;
        e0 = cyc;
    endtask

    always @(posedge a_gclk) a_gclk_n++;
    always @(posedge c_gclk) c_gclk_n++;
    always @(posedge b_gclk) if (b_win) b_gclk_n++;

    // Monitor A: every Synch and every out_valid rise must match the head of its queue.
    always @(negedge clk) begin
        if (a_synch) begin
            if (a_syn_cyc.size() == 0) check("a_unexpected_synch", cyc, -1);
            else begin
                check("a_synch_cycle", cyc, a_syn_cyc.pop_front());
                check("a_synch_blk", int'(a_blk), a_syn_blk.pop_front());
            end
        end
        if (a_valid && !a_valid_q) begin
            if (a_val_cyc.size() == 0) check("a_unexpected_valid", cyc, -1);
            else check("a_valid_cycle", cyc, a_val_cyc.pop_front());
        end
        a_valid_q <= a_valid;
    end

    // Monitor B: free-run Synch cadence and static outputs inside the observation window.
    always @(negedge clk) begin
        if (b_win) begin
            if (cyc >= b_end) b_win <= 1'b0;
            else if (b_synch) begin
                if (b_syn_cyc.size() == 0) check("b_unexpected_synch", cyc, -1);
                else begin
                    check("b_synch_cycle", cyc, b_syn_cyc.pop_front());
                    check("b_synch_blk", int'(b_blk), b_syn_blk.pop_front());
                end
                check("b_out_valid", int'(b_valid), 0);
                check("b_fresh_en", int'(b_fresh), 1);
            end
        end
    end

    // Monitor C
    always @(negedge clk) begin
        if (c_synch) begin
            if (c_syn_cyc.size() == 0) check("c_unexpected_synch", cyc, -1);
            else check("c_synch_cycle", cyc, c_syn_cyc.pop_front());
        end
        if (c_valid && !c_valid_q) begin
            if (c_val_cyc.size() == 0) check("c_unexpected_valid", cyc, -1);
            else check("c_valid_cycle", cyc, c_val_cyc.pop_front());
        end
        c_valid_q <= c_valid;
    end

    initial begin
        int e0, s, s2, r, r2, c0, c1, b_rel;
        b_start = 1'b1;
        b_abort = 1'b1;
        b_out_ready = 1'b1;
        goto(3);
        check("a_rst_in_ready", int'(a_in_ready), 1);
        check("a_rst_busy", int'(a_busy), 0);
        check("a_rst_fresh", int'(a_fresh), 0);
        check("a_rst_valid", int'(a_valid), 0);
        check("a_rst_blk", int'(a_blk), 0);
        check("a_rst_synch", int'(a_synch), 0);
        check("b_rst_in_ready", int'(b_in_ready), 0);
        check("b_rst_busy", int'(b_busy), 0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        c_rst = 1'b0;
        b_rel = cyc;
        for (int k = 0; k < 8; k++) begin
            b_syn_cyc.push_back(b_rel + 10 + 11 * k);
            b_syn_blk.push_back(k % 4);
        end
        b_end = b_rel + 90;
        b_win = 1'b1;

        // Full run with a stalled consumer
        goto(5);
        do_a_start(e0);
        a_push_run(e0);
        goto(e0 + 5);
        check("a_run_fresh", int'(a_fresh), 1);
        check("a_run_busy", int'(a_busy), 1);
        check("a_run_in_ready", int'(a_in_ready), 0);
        goto(e0 + 15);
        check("a_run_blk1", int'(a_blk), 1);
        goto(e0 + 44);
        a_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("a_hold_valid", int'(a_valid), 1);
            check("a_hold_in_ready", int'(a_in_ready), 0);
            check("a_hold_fresh", int'(a_fresh), 0);
            @(posedge clk);
            #1;
        end
        a_start = 1'b0;
        a_out_ready = 1'b1;
        check("a_hold_valid_last", int'(a_valid), 1);
        check("a_done_blk", int'(a_blk), 3);
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        check("a_ack_in_ready", int'(a_in_ready), 1);
        check("a_ack_valid", int'(a_valid), 0);
        check("a_ack_busy", int'(a_busy), 0);
        check("a_ack_blk", int'(a_blk), 0);

        // Abort mid-run, then restart
        goto(e0 + 52);
        do_a_start(s);
        a_push_synch(s + 10, 0);
        goto(s + 15);
        a_abort = 1'b1;
        @(posedge clk);
        #1;
        a_abort = 1'b0;
        check("a_abort_in_ready", int'(a_in_ready), 1);
        check("a_abort_busy", int'(a_busy), 0);
        check("a_abort_fresh", int'(a_fresh), 0);
        check("a_abort_blk", int'(a_blk), 0);
        goto(s + 19);
        do_a_start(s2);
        a_push_run(s2);
        goto(s2 + 44);
        check("a_run2_valid", int'(a_valid), 1);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        check("a_run2_idle", int'(a_in_ready), 1);

        // Reset mid-run, then a clean run from block 0
        goto(cyc + 2);
        do_a_start(r);
        a_push_synch(r + 10, 0);
        a_push_synch(r + 21, 1);
        goto(r + 25);
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        check("a_mrst_in_ready", int'(a_in_ready), 1);
        check("a_mrst_busy", int'(a_busy), 0);
        check("a_mrst_fresh", int'(a_fresh), 0);
        check("a_mrst_valid", int'(a_valid), 0);
        check("a_mrst_blk", int'(a_blk), 0);
        check("a_mrst_synch", int'(a_synch), 0);
        a_rst = 1'b0;
        do_a_start(r2);
        a_push_run(r2);
        goto(r2 + 44);
        check("a_run3_valid", int'(a_valid), 1);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;

        // Minimum configuration, then abort on the Synch cycle
        do_c_start(c0);
        c_syn_cyc.push_back(c0 + 1);
        c_val_cyc.push_back(c0 + 2);
        c_exp_gclk++;
        goto(c0 + 2);
        check("c_valid", int'(c_valid), 1);
        c_out_ready = 1'b1;
        @(posedge clk);
        #1;
        c_out_ready = 1'b0;
        check("c_ack_in_ready", int'(c_in_ready), 1);
        do_c_start(c1);
        goto(c1 + 1);
        c_abort = 1'b1;
        #1;
        check("c_abort_synch", int'(c_synch), 0);
        @(posedge clk);
        #1;
        c_abort = 1'b0;
        check("c_abort_in_ready", int'(c_in_ready), 1);
        check("c_abort_valid", int'(c_valid), 0);
        check("c_abort_busy", int'(c_busy), 0);

        goto((b_end > cyc ? b_end : cyc) + 3);
        check("a_synch_left", a_syn_cyc.size(), 0);
        check("a_valid_left", a_val_cyc.size(), 0);
        check("b_synch_left", b_syn_cyc.size(), 0);
        check("c_synch_left", c_syn_cyc.size(), 0);
        check("c_valid_left", c_val_cyc.size(), 0);
        check("a_gclk_edges", a_gclk_n, a_exp_gclk);
        check("b_gclk_edges", b_gclk_n, 8);
        check("c_gclk_edges", c_gclk_n, c_exp_gclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
